pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Combines three inputs into one consistent set of per-stage write-enable, flush and bubble controls:
  - the hazard unit's load-use stall request
  - the EX-stage branch-taken signal
  - a variable-latency data-memory handshake
- Adds a memory-wait watchdog with a sticky error/halt, and saturating stall/flush performance counters.
- Sits beside the hazard unit; its outputs drive the PC and the pipeline registers directly.

Parameters:
- MEM_TIMEOUT, 8: maximum consecutive request cycles without dmem_ready before halting. Legal range 2..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- hz_stall  in  1  load-use stall request from the hazard unit
- branch_taken  in  1  branch/jump in EX resolved taken
- mem_access  in  1  EX/MEM stage holds a load or store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  access request to data memory
- pc_write  out  1  PC load enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- ex_mem_write  out  1  EX/MEM register enable
- if_id_flush  out  1  clear IF/ID to NOP
- id_ex_flush  out  1  load NOP bubble into ID/EX
- mem_wb_bubble  out  1  load NOP bubble into MEM/WB
- halted  out  1  sticky; set on memory timeout
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 HALT
- stall_cnt  out  CNT_W  cycles with pc_write=0 outside HALT, saturating
- flush_cnt  out  CNT_W  taken-branch flushes, saturating

Behaviour:
- Clocking/reset: one clock, clk; reset is synchronous and active-high, rst.
- While rst=1, outputs are forced regardless of state:
  - pc_write, if_id_write, id_ex_write, ex_mem_write = 0
  - if_id_flush, id_ex_flush, mem_wb_bubble, dmem_req = 0
- After the reset edge: state=RUN, halted=0, counters=0, wait counter=0.
- Control outputs are combinational from state and inputs (zero latency). Only state, the wait counter, halted and the performance counters are registered.
- dmem_req = mem_access while state is RUN or MEM_WAIT; otherwise 0.
- Per-cycle priority in RUN and MEM_WAIT: memory wait > branch flush > load-use stall > normal.
  - Memory wait (mem_access=1, dmem_ready=0):
    - all four write enables = 0; mem_wb_bubble=1; no flushes.
    - branch_taken and hz_stall are ignored this cycle. Frozen stages keep their state, so both are re-evaluated when the freeze ends.
  - Branch flush (branch_taken=1, no memory wait):
    - all enables = 1 (PC loads the target); if_id_flush=1; id_ex_flush=1.
    - hz_stall is ignored.
    - flush_cnt increments.
  - Load-use stall (hz_stall=1 only):
    - pc_write=0, if_id_write=0; id_ex_write=1 with id_ex_flush=1; ex_mem_write=1.
  - Normal: all enables = 1; all flushes and bubbles = 0.
- FSM transitions:
  - RUN -> MEM_WAIT on a memory-wait cycle. The wait counter loads 1, counting that cycle.
  - MEM_WAIT with dmem_ready=1 -> RUN. The pipeline advances that cycle, and branch/stall rules apply to it.
  - MEM_WAIT with mem_access=0 (request withdrawn; protocol violation) -> RUN, with no freeze that cycle.
  - MEM_WAIT with dmem_ready=0: the wait counter increments. At the edge where the counter would reach MEM_TIMEOUT -> HALT and halted=1.
  - Example: MEM_TIMEOUT=8 means 8 consecutive unready request cycles, then HALT.
  - HALT is absorbing until rst:
    - all enables = 0; dmem_req=0; no flushes or bubbles.
    - counters frozen.
- A ready that arrives in the same cycle as the request causes no freeze and no state change.
- stall_cnt increments on every cycle with pc_write=0 in RUN or MEM_WAIT.
- Both counters saturate at all-ones and never wrap.
- Asserting rst in any state, including mid-MEM_WAIT or in HALT, returns the block to reset values at the next edge.

Test Plan:
- Reset, then idle inputs for 3 cycles -> all enables=1, flushes=0, state=0, stall_cnt=0, flush_cnt=0.
- hz_stall=1 for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_flush=1; stall_cnt=1 afterwards. Repeat with branch_taken=1 in the same cycle -> flush wins: pc_write=1, if_id_flush=1, id_ex_flush=1, flush_cnt=1, stall_cnt unchanged.
- mem_access=1 with dmem_ready low for 3 cycles, high on the 4th:
  - cycles 1-3: all enables=0, mem_wb_bubble=1, dmem_req=1, state 0->1.
  - cycle 4: enables=1, then state=0, stall_cnt=3.
- Memory wait with branch_taken held high -> no flush during the wait; in the dmem_ready cycle if_id_flush=1, id_ex_flush=1, flush_cnt+1.
- MEM_TIMEOUT=8, mem_access=1, dmem_ready=0 forever -> after 8 cycles state=2, halted=1, dmem_req=0, all enables 0; counters frozen for 20 more cycles. Then rst=1 for 1 cycle -> state=0, halted=0, counters=0.
- CNT_W=4, hz_stall held 20 cycles -> stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Central pipeline sequencer: merges load-use stalls, taken-branch flushes and the
// data-memory handshake into per-stage enables, with a memory-wait watchdog and
// saturating performance counters.
module pipe_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 8,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hz_stall,
    input  logic             branch_taken,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALT     = 2'd2;

    localparam logic [7:0]       TIMEOUT  = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]       state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic active;
    logic mem_wait;
    logic do_flush;
    logic do_stall;

    // Priority decode: memory wait > branch flush > load-use stall > normal.
    always_comb begin
        active   = !rst && (state_q == ST_RUN || state_q == ST_MEM_WAIT);
        mem_wait = active && mem_access && !dmem_ready;
        do_flush = active && !mem_wait && branch_taken;
        do_stall = active && !mem_wait && !branch_taken && hz_stall;
    end

    // Zero-latency control outputs; all forced low in reset and HALT.
    always_comb begin
        dmem_req      = active && mem_access;
        pc_write      = active && !mem_wait && !do_stall;
        if_id_write   = active && !mem_wait && !do_stall;
        id_ex_write   = active && !mem_wait;
        ex_mem_write  = active && !mem_wait;
        if_id_flush   = do_flush;
        id_ex_flush   = do_flush || do_stall;
        mem_wb_bubble = mem_wait;
    end

    // Next-state: FSM, watchdog and saturating counters.
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        halted_d    = halted_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (active) begin
            if (!pc_write && stall_cnt_q != CNT_MAX) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (do_flush && flush_cnt_q != CNT_MAX) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_RUN: begin
                if (mem_wait) begin
                    state_d = ST_MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_wait) begin
                    wait_d = wait_q + 8'd1;
                    if (wait_q + 8'd1 >= TIMEOUT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end else begin
                    // Ready arrived or the request was withdrawn.
                    state_d = ST_RUN;
                    wait_d  = 8'd0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_HALT;
                halted_d = 1'b1;
            end
        endcase
    end

    // Registered state with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wait_q      <= 8'd0;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halted_q    <= halted_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered status outputs.
    always_comb begin
        state     = state_q;
        halted    = halted_q;
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned MEM_TIMEOUT = 8;
    localparam int unsigned CNT_W       = 4;
    localparam int          CMAX        = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, hz_stall, branch_taken, mem_access, dmem_ready;
    logic             dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble, halted;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .hz_stall     (hz_stall),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .dmem_ready   (dmem_ready),
        .dmem_req     (dmem_req),
        .pc_write     (pc_write),
        .if_id_write  (if_id_write),
        .id_ex_write  (id_ex_write),
        .ex_mem_write (ex_mem_write),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble),
        .halted       (halted),
        .state        (state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: mode names the rule that applies this cycle.
    int m_state = 0;   // 0 RUN, 1 MEM_WAIT, 2 HALT
    int m_wait  = 0;   // consecutive unready request cycles
    int m_halt  = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit m_valid = 0;
    int halt_age = 0;

    task automatic cycle(input bit r, input bit hz, input bit br, input bit ma, input bit rdy);
        typedef enum {MdOff, MdFreeze, MdFlush, MdStall, MdNormal} mode_e;
        mode_e      mode;
        logic [7:0] exp_ctrl, got_ctrl;
        @(negedge clk);
        rst = r; hz_stall = hz; branch_taken = br; mem_access = ma; dmem_ready = rdy;
        #1;
        if (r || m_state == 2 || !m_valid) mode = MdOff;
        else if (ma && !rdy)               mode = MdFreeze;
        else if (br)                       mode = MdFlush;
        else if (hz)                       mode = MdStall;
        else                               mode = MdNormal;
        // {dmem_req, pc, if_id, id_ex, ex_mem, if_id_flush, id_ex_flush, bubble}
        case (mode)
            MdOff:    exp_ctrl = 8'b0_0000_000;
            MdFreeze: exp_ctrl = 8'b1_0000_001;
            MdFlush:  exp_ctrl = {ma, 7'b1111_110};
            MdStall:  exp_ctrl = {ma, 7'b0011_010};
            default:  exp_ctrl = {ma, 7'b1111_000};
        endcase
        got_ctrl = {dmem_req, pc_write, if_id_write, id_ex_write, ex_mem_write,
                    if_id_flush, id_ex_flush, mem_wb_bubble};
        if (r || m_valid) check("ctrl", 32'(got_ctrl), 32'(exp_ctrl));
        if (m_valid) begin
            check("state", 32'(state), 32'(m_state));
            check("halted", 32'(halted), 32'(m_halt));
            check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
            check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        end
        @(posedge clk);
        if (r) begin
            m_state = 0; m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0; m_valid = 1;
        end else if (mode != MdOff) begin
            if (mode == MdFreeze || mode == MdStall) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            if (mode == MdFlush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
            if (mode == MdFreeze) begin
                m_wait = (m_state == 0) ? 1 : m_wait + 1;
                if (m_wait >= MEM_TIMEOUT) begin m_state = 2; m_halt = 1; end
                else m_state = 1;
            end else begin
                m_state = 0; m_wait = 0;
            end
        end
        halt_age = (m_state == 2) ? halt_age + 1 : 0;
    endtask

    initial begin
        int p_mem, p_rdy, p_br, p_hz;
        rst = 1; hz_stall = 0; branch_taken = 0; mem_access = 0; dmem_ready = 0;
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0);
        repeat (3) cycle(0, 0, 0, 0, 0);
        // Load-use stall, then branch racing a stall.
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        // Three unready cycles, ready on the fourth.
        repeat (3) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 0, 0);
        // Wait with branch held high.
        repeat (2) cycle(0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1);
        // Same-cycle ready, then withdrawn request.
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 1, 0, 0, 0);
        // Timeout into HALT, frozen for 20 cycles, then reset.
        repeat (MEM_TIMEOUT) cycle(0, 0, 0, 1, 0);
        repeat (20) cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(0, 1));
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        // Counter saturation.
        repeat (20) cycle(0, 1, 0, 0, 0);
        repeat (20) cycle(0, 0, 1, 0, 0);
        cycle(1, 0, 0, 0, 0);
        // Randomized phases with varying input biases.
        for (int ph = 0; ph < 60; ph++) begin
            p_mem = $urandom_range(0, 100);
            p_rdy = $urandom_range(0, 100);
            p_br  = $urandom_range(0, 60);
            p_hz  = $urandom_range(0, 60);
            for (int i = 0; i < 40; i++) begin
                cycle(($urandom_range(0, 199) == 0) || (halt_age > 20),
                      $urandom_range(0, 99) < p_hz, $urandom_range(0, 99) < p_br,
                      $urandom_range(0, 99) < p_mem, $urandom_range(0, 99) < p_rdy);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
